// File: rtl/load_port_arbiter.sv
// Owner FIFO of outstanding misses, and a round-robin arbiter for the single data-store load port.
// Latency: query issued 1 cycle after grant; ack/hit/ans routed back combinationally in the same cycle.
// Backpressure: req_qry is held until req_ack; no new query issues while a query is in flight or the owner FIFO is full.

// Generic FIFO: pointers wrap at DEPTH (power of 2), so the occupancy count needs one extra bit.
// Latency: a pushed entry can be popped on the following cycle.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; it is never reset because entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module load_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int MEM_IDX_W = 32,
  parameter int LQ_IDX_W  = 4,
  parameter int BLK_W     = 64,
  parameter int MAX_MISS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_qry,
  input  logic [NREQ*MEM_IDX_W-1:0] req_mem_idx,
  input  logic [NREQ*LQ_IDX_W-1:0] req_lq_idx,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          req_hit,
  output logic [NREQ-1:0]          req_ans,
  output logic [LQ_IDX_W-1:0]      req_head,
  output logic [BLK_W-1:0]         req_blk,
  output logic                     ds_qry,
  output logic [MEM_IDX_W-1:0]     ds_mem_idx,
  output logic [LQ_IDX_W-1:0]      ds_lq_idx,
  input  logic                     ds_ack,
  input  logic [LQ_IDX_W-1:0]      ds_ack_head,
  input  logic                     ds_hit,
  input  logic [BLK_W-1:0]         ds_hit_blk,
  input  logic                     ds_ans,
  input  logic [LQ_IDX_W-1:0]      ds_ans_head,
  input  logic [BLK_W-1:0]         ds_ans_blk,
  output logic                     err
);
  localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [OWN_W-1:0] rr_ptr;
  logic [OWN_W-1:0] owner;
  logic [OWN_W-1:0] win_idx;
  logic             win_vld;
  logic             ack_evt;
  logic             miss_push;
  logic             ans_pop;
  logic [OWN_W-1:0] fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             err_set;

  // An ack counts only while a query is in flight; a stray ack in IDLE merely flags an error.
  assign ack_evt   = ds_ack && (state == WAIT);
  assign miss_push = ack_evt && !ds_hit;
  assign ans_pop   = ds_ans && !fifo_empty;

  // Round-robin pick: first requesting slot at or after rr_ptr, wrapping from NREQ-1 to 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req_qry[(int'(rr_ptr) + k) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = OWN_W'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  fifo #(.W(OWN_W), .DEPTH(MAX_MISS)) u_owner_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (miss_push),
    .push_dat (owner),
    .pop      (ans_pop),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Issue/complete FSM: in IDLE, grant and launch a query; in WAIT, hold the payload until the data store acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      ds_qry     <= 1'b0;
      ds_mem_idx <= '0;
      ds_lq_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Fullness is taken from the current count, so a same-cycle pop does not unblock the issue.
          if (win_vld && !fifo_full) begin
            owner      <= win_idx;
            ds_qry     <= 1'b1;
            ds_mem_idx <= req_mem_idx[int'(win_idx)*MEM_IDX_W +: MEM_IDX_W];
            ds_lq_idx  <= req_lq_idx[int'(win_idx)*LQ_IDX_W +: LQ_IDX_W];
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (ds_ack) begin
            ds_qry <= 1'b0;
            rr_ptr <= (owner == OWN_W'(NREQ-1)) ? '0 : owner + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky protocol-error flag for data-store behaviour this block cannot handle.
  assign err_set = (ds_ans && fifo_empty) || (ds_ack && (state == IDLE)) ||
                   (ack_evt && (ds_ack_head != ds_lq_idx)) || (ds_ack && ds_ans);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Return routing: ack/hit data takes precedence on the shared head/blk lines; they read zero when nothing returns.
  always_comb begin
    req_ack  = '0;
    req_hit  = '0;
    req_ans  = '0;
    req_head = '0;
    req_blk  = '0;
    if (ans_pop) begin
      req_ans  = NREQ'(1) << fifo_head;
      req_head = ds_ans_head;
      req_blk  = ds_ans_blk;
    end
    if (ack_evt) begin
      req_ack  = NREQ'(1) << owner;
      req_hit  = ds_hit ? (NREQ'(1) << owner) : '0;
      req_head = ds_ack_head;
      req_blk  = ds_hit_blk;
    end
  end
endmodule

// File: tb/tb_load_port_arbiter.sv
// Directed bench for load_port_arbiter: a table of per-cycle inputs/expected outputs plus hand sequences.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Every expectation below is worked out by hand from the intended behaviour.
module tb_load_port_arbiter;
  logic        clk;
  logic        rst_n;
  logic [1:0]  req_qry;
  logic [63:0] req_mem_idx;
  logic [7:0]  req_lq_idx;
  logic [1:0]  req_ack, req_hit, req_ans;
  logic [3:0]  req_head;
  logic [63:0] req_blk;
  logic        ds_qry;
  logic [31:0] ds_mem_idx;
  logic [3:0]  ds_lq_idx;
  logic        ds_ack, ds_hit, ds_ans;
  logic [3:0]  ds_ack_head, ds_ans_head;
  logic [63:0] ds_hit_blk, ds_ans_blk;
  logic        err;

  int checks = 0;
  int errors = 0;

  load_port_arbiter #(.NREQ(2), .MEM_IDX_W(32), .LQ_IDX_W(4), .BLK_W(64), .MAX_MISS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_qry(req_qry), .req_mem_idx(req_mem_idx), .req_lq_idx(req_lq_idx),
    .req_ack(req_ack), .req_hit(req_hit), .req_ans(req_ans), .req_head(req_head), .req_blk(req_blk),
    .ds_qry(ds_qry), .ds_mem_idx(ds_mem_idx), .ds_lq_idx(ds_lq_idx),
    .ds_ack(ds_ack), .ds_ack_head(ds_ack_head), .ds_hit(ds_hit), .ds_hit_blk(ds_hit_blk),
    .ds_ans(ds_ans), .ds_ans_head(ds_ans_head), .ds_ans_blk(ds_ans_blk), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  qry;
    logic        ack, hit, ans;
    logic [3:0]  ack_head, ans_head;
    logic [63:0] hit_blk, ans_blk;
    logic        e_qry;
    logic [3:0]  e_lq;
    logic [1:0]  e_ack, e_hit, e_ans;
    logic [3:0]  e_head;
    logic [63:0] e_blk;
    logic        e_err;
    logic        chk_dat;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] qry, input logic ack, input logic hit, input logic ans,
                     input logic [3:0] ack_head, input logic [3:0] ans_head,
                     input logic [63:0] hit_blk, input logic [63:0] ans_blk,
                     input logic e_qry, input logic [3:0] e_lq, input logic [1:0] e_ack,
                     input logic [1:0] e_hit, input logic [1:0] e_ans, input logic [3:0] e_head,
                     input logic [63:0] e_blk, input logic e_err, input logic chk_dat);
    vec_t v;
    v.qry = qry; v.ack = ack; v.hit = hit; v.ans = ans;
    v.ack_head = ack_head; v.ans_head = ans_head; v.hit_blk = hit_blk; v.ans_blk = ans_blk;
    v.e_qry = e_qry; v.e_lq = e_lq; v.e_ack = e_ack; v.e_hit = e_hit; v.e_ans = e_ans;
    v.e_head = e_head; v.e_blk = e_blk; v.e_err = e_err; v.chk_dat = chk_dat;
    vq.push_back(v);
  endtask

  // Cycle with no data-store activity and no outstanding query.
  task automatic add_idle(input logic [1:0] qry, input logic e_err);
    add(qry, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, e_err, 1);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle_ds();
    ds_ack = 0; ds_hit = 0; ds_ans = 0;
    ds_ack_head = 0; ds_ans_head = 0; ds_hit_blk = 0; ds_ans_blk = 0;
  endtask

  initial begin
    // Requester 0: lq_idx 3, mem_idx 0x100; requester 1: lq_idx 5, mem_idx 0x200.
    req_mem_idx = {32'h200, 32'h100};
    req_lq_idx  = {4'd5, 4'd3};
    req_qry     = 2'b00;
    drive_idle_ds();
    rst_n = 1'b0;

    // Test 1: both request continuously, every query hits -> grants alternate 0,1,0,1.
    add_idle(2'b11, 0);
    add(2'b11, 1, 1, 0, 3, 0, 64'hA0, 0, 1, 3, 2'b01, 2'b01, 2'b00, 3, 64'hA0, 0, 1);
    add_idle(2'b11, 0);
    add(2'b11, 1, 1, 0, 5, 0, 64'hA1, 0, 1, 5, 2'b10, 2'b10, 2'b00, 5, 64'hA1, 0, 1);
    add_idle(2'b11, 0);
    add(2'b11, 1, 1, 0, 3, 0, 64'hA2, 0, 1, 3, 2'b01, 2'b01, 2'b00, 3, 64'hA2, 0, 1);
    add_idle(2'b11, 0);
    add(2'b11, 1, 1, 0, 5, 0, 64'hA3, 0, 1, 5, 2'b10, 2'b10, 2'b00, 5, 64'hA3, 0, 1);
    // Test 2: requester 0 misses, then its answer is routed back.
    add_idle(2'b01, 0);
    add(2'b01, 1, 0, 0, 3, 0, 0, 0, 1, 3, 2'b01, 2'b00, 2'b00, 3, 0, 0, 1);
    add(2'b00, 0, 0, 1, 0, 3, 0, 64'hDEAD, 0, 0, 2'b00, 2'b00, 2'b01, 3, 64'hDEAD, 0, 1);
    // Test 4: misses owned by 0,1,0 are answered in acceptance order.
    add_idle(2'b01, 0);
    add(2'b01, 1, 0, 0, 3, 0, 0, 0, 1, 3, 2'b01, 2'b00, 2'b00, 3, 0, 0, 1);
    add_idle(2'b10, 0);
    add(2'b10, 1, 0, 0, 5, 0, 0, 0, 1, 5, 2'b10, 2'b00, 2'b00, 5, 0, 0, 1);
    add_idle(2'b01, 0);
    add(2'b01, 1, 0, 0, 3, 0, 0, 0, 1, 3, 2'b01, 2'b00, 2'b00, 3, 0, 0, 1);
    add(2'b00, 0, 0, 1, 0, 3, 0, 64'hB0, 0, 0, 2'b00, 2'b00, 2'b01, 3, 64'hB0, 0, 1);
    add(2'b00, 0, 0, 1, 0, 5, 0, 64'hB1, 0, 0, 2'b00, 2'b00, 2'b10, 5, 64'hB1, 0, 1);
    add(2'b00, 0, 0, 1, 0, 3, 0, 64'hB2, 0, 0, 2'b00, 2'b00, 2'b01, 3, 64'hB2, 0, 1);
    // Test 3: four misses from requester 1 fill the owner FIFO; the fifth query waits for an answer.
    for (int k = 0; k < 4; k++) begin
      add_idle(2'b10, 0);
      add(2'b10, 1, 0, 0, 5, 0, 0, 0, 1, 5, 2'b10, 2'b00, 2'b00, 5, 0, 0, 1);
    end
    add_idle(2'b10, 0);
    add(2'b10, 0, 0, 1, 0, 5, 0, 64'hC0, 0, 0, 2'b00, 2'b00, 2'b10, 5, 64'hC0, 0, 1);
    add_idle(2'b10, 0);
    add(2'b10, 1, 0, 0, 5, 0, 0, 0, 1, 5, 2'b10, 2'b00, 2'b00, 5, 0, 0, 1);
    for (int k = 0; k < 4; k++)
      add(2'b00, 0, 0, 1, 0, 5, 0, 64'hC1 + k, 0, 0, 2'b00, 2'b00, 2'b10, 5, 64'hC1 + k, 0, 1);
    // Test 5a: answer with an empty FIFO is not routed and sets the sticky error.
    add(2'b00, 0, 0, 1, 0, 7, 0, 64'hEE, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    add_idle(2'b00, 1);
    add_idle(2'b00, 1);

    // Reset state.
    #12;
    chk("rst_ds_qry", ds_qry, 0);
    chk("rst_ds_mem_idx", ds_mem_idx, 0);
    chk("rst_ds_lq_idx", ds_lq_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_req_ans", req_ans, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      @(negedge clk);
      req_qry = v.qry;
      ds_ack = v.ack; ds_hit = v.hit; ds_ans = v.ans;
      ds_ack_head = v.ack_head; ds_ans_head = v.ans_head;
      ds_hit_blk = v.hit_blk; ds_ans_blk = v.ans_blk;
      #1;
      chk($sformatf("v%0d ds_qry", i), ds_qry, v.e_qry);
      if (v.e_qry) begin
        chk($sformatf("v%0d ds_lq_idx", i), ds_lq_idx, v.e_lq);
        chk($sformatf("v%0d ds_mem_idx", i), ds_mem_idx, (v.e_lq == 4'd3) ? 64'h100 : 64'h200);
      end
      chk($sformatf("v%0d req_ack", i), req_ack, v.e_ack);
      chk($sformatf("v%0d req_hit", i), req_hit, v.e_hit);
      chk($sformatf("v%0d req_ans", i), req_ans, v.e_ans);
      chk($sformatf("v%0d err", i), err, v.e_err);
      if (v.chk_dat) begin
        chk($sformatf("v%0d req_head", i), req_head, v.e_head);
        chk($sformatf("v%0d req_blk", i), req_blk, v.e_blk);
      end
    end

    // Test 5b: park a miss in the FIFO, launch another query, then reset mid-WAIT.
    @(negedge clk);
    drive_idle_ds();
    req_qry = 2'b01;
    @(negedge clk);
    ds_ack = 1; ds_hit = 0; ds_ack_head = 4'd3;
    #1 chk("seq_miss_ack", req_ack, 2'b01);
    @(negedge clk);
    drive_idle_ds();
    req_qry = 2'b01;
    @(negedge clk);
    req_qry = 2'b00;
    #1 chk("seq_wait_ds_qry", ds_qry, 1);
    ds_ack = 1; ds_ack_head = 4'd3;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ds_qry", ds_qry, 0);
    chk("midrst_req_ack", req_ack, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    drive_idle_ds();
    rst_n = 1'b1;
    // The parked miss must be gone: an answer now is not routed and raises err.
    @(negedge clk);
    ds_ans = 1; ds_ans_head = 4'd3; ds_ans_blk = 64'hDEAD;
    #1 chk("post_rst_req_ans", req_ans, 0);
    @(negedge clk);
    drive_idle_ds();
    #1 chk("post_rst_err", err, 1);
    @(negedge clk);
    #1 chk("post_rst_ds_qry", ds_qry, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
